// File: rtl/spdif_frame_sequencer.sv
// rtl/spdif_frame_sequencer.sv - S/PDIF block/frame/slot sequencer feeding a biphase-mark encoder
// Walks 192 frames x 2 subframes x 32 slots, one slot per slot_tick, with registered per-slot outputs.
module spdif_frame_sequencer #(
   parameter logic [31:0] CS_WORD  = 32'h0000_0204,
   parameter logic        USER_BIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        slot_tick,
   input  logic [23:0] sample_l,
   input  logic [23:0] sample_r,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic [1:0]  pre_type,
   output logic        data_bit,
   output logic        subframe_pulse,
   output logic        frame_pulse,
   output logic        block_pulse,
   output logic        active,
   output logic        underrun
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [1:0] PRE_NONE = 2'd0;
   localparam logic [1:0] PRE_B    = 2'd1;
   localparam logic [1:0] PRE_M    = 2'd2;
   localparam logic [1:0] PRE_W    = 2'd3;

   state_t      state;
   logic [4:0]  slot_cnt;
   logic        sub;
   logic [7:0]  frame_cnt;
   logic [23:0] samp_l;
   logic [23:0] samp_r;
   logic        v_flag;
   logic        parity;

   logic        boundary;
   logic        emit;
   logic        stop;
   logic [4:0]  p_slot;
   logic        p_sub;
   logic [7:0]  p_frame;
   logic        frame_start;
   logic [4:0]  bit_idx;
   logic [23:0] shifted;
   logic        cs_bit;
   logic        slot_bit;
   logic [1:0]  slot_pre;

   // p_* is the position the next tick will present; from IDLE that is always frame 0, left, slot 0.
   always_comb begin
      boundary = (slot_cnt == 5'd31) && sub;
      stop     = slot_tick && (state == RUN) && boundary && !enable;
      emit     = slot_tick && ((state == IDLE) ? enable : !(boundary && !enable));

      if (state == IDLE) begin
         p_slot  = 5'd0;
         p_sub   = 1'b0;
         p_frame = 8'd0;
      end else begin
         p_slot = slot_cnt + 5'd1;
         p_sub  = sub ^ (slot_cnt == 5'd31);
         if (boundary)
            p_frame = (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
         else
            p_frame = frame_cnt;
      end

      frame_start = (p_slot == 5'd0) && !p_sub;
      bit_idx     = p_slot - 5'd4;
      shifted     = (p_sub ? samp_r : samp_l) >> bit_idx;
      cs_bit      = (p_frame < 8'd32) ? CS_WORD[p_frame[4:0]] : 1'b0;

      case (p_slot)
         5'd28:   slot_bit = v_flag;
         5'd29:   slot_bit = USER_BIT;
         5'd30:   slot_bit = cs_bit;
         5'd31:   slot_bit = parity;
         default: slot_bit = (p_slot >= 5'd4) ? shifted[0] : 1'b0;
      endcase

      if (p_slot < 5'd4)
         slot_pre = p_sub ? PRE_W : ((p_frame == 8'd0) ? PRE_B : PRE_M);
      else
         slot_pre = PRE_NONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         slot_cnt       <= 5'd0;
         sub            <= 1'b0;
         frame_cnt      <= 8'd0;
         samp_l         <= 24'd0;
         samp_r         <= 24'd0;
         v_flag         <= 1'b0;
         parity         <= 1'b0;
         sample_ready   <= 1'b0;
         pre_type       <= PRE_NONE;
         data_bit       <= 1'b0;
         subframe_pulse <= 1'b0;
         frame_pulse    <= 1'b0;
         block_pulse    <= 1'b0;
         active         <= 1'b0;
         underrun       <= 1'b0;
      end else begin
         sample_ready   <= 1'b0;
         underrun       <= 1'b0;
         subframe_pulse <= 1'b0;
         frame_pulse    <= 1'b0;
         block_pulse    <= 1'b0;

         if (stop) begin
            state     <= IDLE;
            active    <= 1'b0;
            pre_type  <= PRE_NONE;
            data_bit  <= 1'b0;
            slot_cnt  <= 5'd0;
            sub       <= 1'b0;
            frame_cnt <= 8'd0;
            parity    <= 1'b0;
         end else if (emit) begin
            state          <= RUN;
            active         <= 1'b1;
            slot_cnt       <= p_slot;
            sub            <= p_sub;
            frame_cnt      <= p_frame;
            pre_type       <= slot_pre;
            data_bit       <= slot_bit;
            subframe_pulse <= (p_slot == 5'd0);
            frame_pulse    <= frame_start;
            block_pulse    <= frame_start && (p_frame == 8'd0);

            // Slot 31 sends the accumulated parity, so only 4..30 feed it.
            if (p_slot == 5'd0)
               parity <= 1'b0;
            else if ((p_slot >= 5'd4) && (p_slot <= 5'd30))
               parity <= parity ^ slot_bit;

            if (frame_start) begin
               if (sample_valid) begin
                  samp_l       <= sample_l;
                  samp_r       <= sample_r;
                  v_flag       <= 1'b0;
                  sample_ready <= 1'b1;
               end else begin
                  samp_l   <= 24'd0;
                  samp_r   <= 24'd0;
                  v_flag   <= 1'b1;
                  underrun <= 1'b1;
               end
            end
         end
      end
   end
endmodule
